// File: rtl/mac_pkg.sv
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared types and constants for the MAC array sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WLOAD   = 3'd1,
    WGAP    = 3'd2,
    EXEC    = 3'd3,
    DRAIN   = 3'd4,
    OS_EXEC = 3'd5,
    OS_WAIT = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int DEF_ROW     = 8;
  localparam int DEF_COL     = 8;
  localparam int DEF_ACC_LEN = 27;

endpackage

`default_nettype wire

// File: rtl/mac_seq_addr_gen.sv
// ============================================================================
// Module  : mac_seq_addr_gen
// Brief   : SRAM address counter with load, increment and silent wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_addr_gen #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load) begin
      r_addr <= load_addr;
    end else if (inc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/mac_array_seq.sv
// ============================================================================
// Module  : mac_array_seq
// Brief   : WS/OS dataflow sequencer for the ROW x COL mac_tile array.
//           Optional busy-cycle counter enabled by MAC_SEQ_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_seq
  import mac_pkg::*;
#(
  parameter int ROW        = DEF_ROW,
  parameter int COL        = DEF_COL,
  parameter int ADDR_W     = 11,
  parameter int ACC_LEN    = DEF_ACC_LEN,
  parameter int OS_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] num_vec,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              weight_or_output,
  output logic [1:0]        inst_w,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic [COL-1:0]    os_valid_in,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int c_MAX_A = (ROW + COL > ACC_LEN + 1) ? (ROW + COL) : (ACC_LEN + 1);
  localparam int c_MAX_B = ((1 << ADDR_W) > OS_TIMEOUT) ? (1 << ADDR_W) : OS_TIMEOUT;
  localparam int c_CNT_W = $clog2((c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B);

  localparam logic [c_CNT_W-1:0] c_ROW_LAST   = c_CNT_W'(ROW - 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(ROW + COL - 2);
  localparam logic [c_CNT_W-1:0] c_ACC_LAST   = c_CNT_W'(ACC_LEN);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(OS_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_num_vec;
  logic [COL-1:0]      r_seen;
  logic [1:0]          r_inst;
  logic                r_wo;
  logic                r_err;
  logic [1:0]          w_inst;
  logic                w_act_en;
  logic                w_w_en;
  logic                w_timeout;
  logic                w_start_acc;
  logic                w_all_seen;
  logic [c_CNT_W-1:0]  w_vec_last;

  assign w_start_acc = start && (r_state == IDLE);
  // Current-cycle valids count too, so the last column completes without an extra wait cycle.
  assign w_all_seen  = &(r_seen | os_valid_in);
  assign w_vec_last  = c_CNT_W'(r_num_vec - ADDR_W'(1));

  always_comb begin
    w_next    = r_state;
    w_inst    = INST_NOP;
    w_act_en  = 1'b0;
    w_w_en    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = mode ? OS_EXEC : WLOAD;
      end
      WLOAD: begin
        w_w_en = 1'b1;
        w_inst = INST_LOAD;
        if (r_cnt == c_ROW_LAST) w_next = WGAP;
      end
      WGAP: begin
        w_next = (r_num_vec != '0) ? EXEC : DRAIN;
      end
      EXEC: begin
        w_act_en = 1'b1;
        w_inst   = INST_EXEC;
        if (r_cnt == w_vec_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) w_next = DONE;
      end
      OS_EXEC: begin
        w_act_en = 1'b1;
        w_w_en   = 1'b1;
        w_inst   = INST_EXEC;
        if (r_cnt == c_ACC_LAST) w_next = OS_WAIT;
      end
      OS_WAIT: begin
        if (w_all_seen) begin
          w_next = DONE;
        end else if (r_cnt == c_TO_LAST) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_num_vec <= '0;
      r_seen    <= '0;
      r_inst    <= INST_NOP;
      r_wo      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inst  <= w_inst;
      r_cnt   <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + c_CNT_W'(1);
      r_seen  <= (r_state == OS_WAIT) ? (r_seen | os_valid_in) : '0;
      if (w_start_acc) begin
        r_wo      <= mode;
        r_num_vec <= num_vec;
        r_err     <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_act_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (w_start_acc),
    .load_addr (base_addr),
    .inc       (w_act_en),
    .addr      (act_rd_addr)
  );

  mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_w_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (w_start_acc),
    .load_addr (base_addr),
    .inc       (w_w_en),
    .addr      (w_rd_addr)
  );

  assign act_rd_en        = w_act_en;
  assign w_rd_en          = w_w_en;
  assign inst_w           = r_inst;
  assign weight_or_output = r_wo;
  assign err              = r_err;
  assign busy             = (r_state != IDLE);
  assign done             = (r_state == DONE);

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_start_acc) begin
      r_perf <= '0;
    end else if (busy && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_array_seq.sv
// ============================================================================
// Module  : tb_mac_array_seq
// Brief   : Directed self-checking bench for mac_array_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_array_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [10:0] num_vec = '0;
  logic [10:0] base_addr = '0;
  logic [7:0]  os_valid_in = '0;
  logic        weight_or_output;
  logic [1:0]  inst_w;
  logic        act_rd_en;
  logic [10:0] act_rd_addr;
  logic        w_rd_en;
  logic [10:0] w_rd_addr;
  logic        busy;
  logic        done;
  logic        err;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mac_array_seq dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .mode             (mode),
    .num_vec          (num_vec),
    .base_addr        (base_addr),
    .weight_or_output (weight_or_output),
    .inst_w           (inst_w),
    .act_rd_en        (act_rd_en),
    .act_rd_addr      (act_rd_addr),
    .w_rd_en          (w_rd_en),
    .w_rd_addr        (w_rd_addr),
    .os_valid_in      (os_valid_in),
    .busy             (busy),
    .done             (done),
    .err              (err)
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    .perf_cycles      (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic m, input logic [10:0] nv, input logic [10:0] base);
    @(negedge clk);
    start = 1'b1; mode = m; num_vec = nv; base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({weight_or_output, inst_w, act_rd_en, act_rd_addr, w_rd_en, w_rd_addr, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=all zero",
               {weight_or_output, inst_w, act_rd_en, act_rd_addr, w_rd_en, w_rd_addr, busy, done, err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, act_rd_en, w_rd_en, inst_w} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_idle got=%b exp=000000", {busy, done, act_rd_en, w_rd_en, inst_w});
    end
  endtask

  // Cycle c counts negedges after the accepting edge; job ends with DONE at c=25+nv.
  task automatic test_ws(input logic [10:0] nv, input logic [10:0] base, input bit inject, input string name);
    int          last;
    logic        e_wen, e_aen, e_done, e_busy;
    logic [1:0]  e_inst;
    logic [10:0] e_waddr, e_aaddr;
    last = 26 + int'(nv);
    pulse_start(1'b0, nv, base);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      e_wen   = (c >= 1) && (c <= 8);
      e_aen   = (c >= 10) && (c < 10 + int'(nv));
      e_waddr = base + 11'(c - 1);
      e_aaddr = base + 11'(c - 10);
      e_inst  = ((c >= 2) && (c <= 9)) ? 2'b01 :
                ((c >= 11) && (c <= 10 + int'(nv))) ? 2'b10 : 2'b00;
      e_done  = (c == 25 + int'(nv));
      e_busy  = (c <= 25 + int'(nv));
      n_cmp++;
      if (w_rd_en !== e_wen) begin
        n_bad++; $display("FAIL %s c=%0d w_rd_en got=%b exp=%b", name, c, w_rd_en, e_wen);
      end
      if (e_wen) begin
        n_cmp++;
        if (w_rd_addr !== e_waddr) begin
          n_bad++; $display("FAIL %s c=%0d w_rd_addr got=%0d exp=%0d", name, c, w_rd_addr, e_waddr);
        end
      end
      n_cmp++;
      if (act_rd_en !== e_aen) begin
        n_bad++; $display("FAIL %s c=%0d act_rd_en got=%b exp=%b", name, c, act_rd_en, e_aen);
      end
      if (e_aen) begin
        n_cmp++;
        if (act_rd_addr !== e_aaddr) begin
          n_bad++; $display("FAIL %s c=%0d act_rd_addr got=%0d exp=%0d", name, c, act_rd_addr, e_aaddr);
        end
      end
      n_cmp++;
      if (inst_w !== e_inst) begin
        n_bad++; $display("FAIL %s c=%0d inst_w got=%b exp=%b", name, c, inst_w, e_inst);
      end
      n_cmp++;
      if ({done, busy, weight_or_output, err} !== {e_done, e_busy, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL %s c=%0d done/busy/wo/err got=%b exp=%b", name, c,
                 {done, busy, weight_or_output, err}, {e_done, e_busy, 1'b0, 1'b0});
      end
      if (inject) begin
        if (c == 11) begin start = 1'b1; mode = 1'b1; base_addr = 11'd100; num_vec = 11'd7; end
        if (c == 12) start = 1'b0;
        if (c == 25 + int'(nv)) start = 1'b1;
        if (c == 26 + int'(nv)) start = 1'b0;
      end
    end
  endtask

  // OS job: 28 strobe cycles, OS_WAIT from c=29; done_c is the expected DONE cycle.
  task automatic test_os(input logic [10:0] base, input int done_c, input bit complete, input string name);
    logic        e_en, e_done, e_busy, e_err;
    logic [1:0]  e_inst;
    logic [10:0] e_addr;
    pulse_start(1'b1, 11'd0, base);
    if (!complete) os_valid_in = 8'h7F;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      e_en   = (c <= 28);
      e_addr = base + 11'(c - 1);
      e_inst = ((c >= 2) && (c <= 29)) ? 2'b10 : 2'b00;
      e_done = (c == done_c);
      e_busy = (c <= done_c);
      e_err  = !complete && (c >= done_c);
      n_cmp++;
      if ({act_rd_en, w_rd_en} !== {e_en, e_en}) begin
        n_bad++; $display("FAIL %s c=%0d act/w_rd_en got=%b exp=%b", name, c, {act_rd_en, w_rd_en}, {e_en, e_en});
      end
      if (e_en) begin
        n_cmp++;
        if ({act_rd_addr, w_rd_addr} !== {e_addr, e_addr}) begin
          n_bad++; $display("FAIL %s c=%0d addrs got=%0d/%0d exp=%0d", name, c, act_rd_addr, w_rd_addr, e_addr);
        end
      end
      n_cmp++;
      if (inst_w !== e_inst) begin
        n_bad++; $display("FAIL %s c=%0d inst_w got=%b exp=%b", name, c, inst_w, e_inst);
      end
      n_cmp++;
      if ({done, busy, weight_or_output, err} !== {e_done, e_busy, 1'b1, e_err}) begin
        n_bad++;
        $display("FAIL %s c=%0d done/busy/wo/err got=%b exp=%b", name, c,
                 {done, busy, weight_or_output, err}, {e_done, e_busy, 1'b1, e_err});
      end
      if (complete) begin
        if (c == 31) os_valid_in = 8'h0F;
        if (c == 32) os_valid_in = 8'hF0;
        if (c == 33) os_valid_in = 8'h00;
      end
    end
    os_valid_in = 8'h00;
  endtask

  task automatic test_err_clear();
    bit seen_done;
    seen_done = 1'b0;
    pulse_start(1'b0, 11'd1, 11'd0);
    @(negedge clk);
    n_cmp++;
    if ({err, busy, weight_or_output} !== 3'b010) begin
      n_bad++; $display("FAIL err_clear err/busy/wo got=%b exp=010", {err, busy, weight_or_output});
    end
    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b1) begin
      n_bad++; $display("FAIL err_clear_done got=%b exp=1 (no done within bound)", seen_done);
    end
  endtask

  task automatic test_reset_mid_exec();
    int active;
    active = 0;
    pulse_start(1'b0, 11'd4, 11'd0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({weight_or_output, inst_w, act_rd_en, act_rd_addr, w_rd_en, w_rd_addr, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_exec got=%b exp=all zero",
               {weight_or_output, inst_w, act_rd_en, act_rd_addr, w_rd_en, w_rd_addr, busy, done, err});
    end
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || done || act_rd_en || w_rd_en || (inst_w != 2'b00)) active++;
    end
    n_cmp++;
    if (active !== 0) begin
      n_bad++; $display("FAIL reset_stays_idle active_cycles got=%0d exp=0", active);
    end
  endtask

`ifdef MAC_SEQ_PERF_CNT_EN
  task automatic test_perf();
    pulse_start(1'b0, 11'd4, 11'd0);
    repeat (35) @(negedge clk);
    n_cmp++;
    if (perf_cycles !== 32'd29) begin
      n_bad++; $display("FAIL perf_cycles got=%0d exp=29", perf_cycles);
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_ws(11'd4, 11'd0, 1'b0, "ws_nv4");
    test_ws(11'd0, 11'd0, 1'b0, "ws_nv0");
    test_os(11'd16, 33, 1'b1, "os_valid");
    test_os(11'd0, 93, 1'b0, "os_timeout");
    test_err_clear();
    test_ws(11'd4, 11'd0, 1'b1, "ws_start_ignored");
    test_reset_mid_exec();
    test_ws(11'd2, 11'd2046, 1'b0, "ws_wrap");
`ifdef MAC_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
